// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver: FSM states, bus width, PC mask helper.
package branch_resolver_pkg;
  localparam int DATA_W = 32;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Low w bits set; w >= 32 yields all ones (shift-out then -1 wraps).
  function automatic logic [DATA_W-1:0] pc_mask(input int w);
    return (DATA_W'(1) << w) - DATA_W'(1);
  endfunction
endpackage

// File: rtl/branch_resolver_train_fifo.sv
// Synchronous training FIFO with extra-MSB pointers; head holds its last value when empty.
module branch_resolver_train_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               wr_ptr, rd_ptr;
  logic [DEPTH-1:0][W-1:0]   mem;
  logic [W-1:0]              last_q;
  logic                      do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      // Remember the visible head so it stays on the outputs once drained.
      if (!empty) last_q <= mem[rd_ptr[AW-1:0]];
    end
  end
endmodule

// File: rtl/branch_resolver.sv
// Resolves branches against predictions, queues training updates, and drives mispredict recovery.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int TRAIN_DEPTH = 4,
  parameter int PC_W        = 17,
  parameter int FLUSH_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_pc,
  input  logic              res_taken,
  input  logic [DATA_W-1:0] res_target,
  input  logic [DATA_W-1:0] res_pred_pc,
  output logic              train_valid,
  input  logic              train_ack,
  output logic [DATA_W-1:0] train_pc,
  output logic              train_taken,
  output logic              flush,
  output logic [DATA_W-1:0] flush_pc,
  output logic [15:0]       mispred_cnt
);
  localparam logic [DATA_W-1:0] PC_MASK = pc_mask(PC_W);
  localparam int HW = $clog2(FLUSH_HOLD + 1);

  state_t            state;
  logic [HW-1:0]     hold_cnt;
  logic [DATA_W-1:0] actual;
  logic              mispred, accept, pop, fifo_full, fifo_empty;
  logic [PC_W:0]     head;

  // Carry out of the significant PC bits is dropped by the mask.
  assign actual    = (res_taken ? res_target : res_pc + DATA_W'(4)) & PC_MASK;
  assign mispred   = (actual != (res_pred_pc & PC_MASK));
  assign res_ready = rst & (state == ST_IDLE) & ~fifo_full;
  assign accept    = res_valid & res_ready & rdy;
  assign pop       = train_valid & train_ack & rdy;

  assign train_valid = ~fifo_empty;
  assign train_taken = head[PC_W];
  assign train_pc    = DATA_W'(head[PC_W-1:0]);

  branch_resolver_train_fifo #(.W(PC_W + 1), .DEPTH(TRAIN_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   ({res_taken, res_pc[PC_W-1:0]}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      flush       <= 1'b0;
      flush_pc    <= '0;
      mispred_cnt <= '0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: if (accept && mispred) begin
          state    <= ST_FLUSH;
          flush    <= 1'b1;
          flush_pc <= actual;
          if (mispred_cnt != CNT_MAX) mispred_cnt <= mispred_cnt + 16'd1;
        end
        ST_FLUSH: begin
          flush    <= 1'b0;
          state    <= ST_HOLD;
          hold_cnt <= HW'(FLUSH_HOLD);
        end
        ST_HOLD: begin
          if (hold_cnt == HW'(1)) state <= ST_IDLE;
          else                    hold_cnt <= hold_cnt - HW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed plus randomized bench for branch_resolver against a queue/countdown reference model.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int PC_W  = 17;
  localparam int FH    = 2;
  localparam logic [31:0] MASK = 32'h0001_FFFF;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic        res_valid = 1'b0, res_taken = 1'b0, train_ack = 1'b0;
  logic [31:0] res_pc = '0, res_target = '0, res_pred_pc = '0;
  logic        res_ready, train_valid, train_taken, flush;
  logic [31:0] train_pc, flush_pc;
  logic [15:0] mispred_cnt;

  branch_resolver #(.TRAIN_DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_HOLD(FH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_pc(res_pred_pc),
    .train_valid(train_valid), .train_ack(train_ack), .train_pc(train_pc), .train_taken(train_taken),
    .flush(flush), .flush_pc(flush_pc), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic taken; } ent_t;
  ent_t        q[$];
  ent_t        last;
  int          busy;   // cycles of recovery left; FH+1 means the flush cycle
  logic [31:0] m_fpc;
  int          m_cnt;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    busy = 0; m_fpc = '0; m_cnt = 0;
    last = '{32'h0, 1'b0};
  endtask

  task automatic check_all();
    logic ready_e;
    ready_e = (busy == 0) && (q.size() < DEPTH);
    chk("res_ready",   32'(res_ready),   32'(ready_e));
    chk("train_valid", 32'(train_valid), 32'(q.size() > 0));
    chk("train_pc",    train_pc,         q.size() > 0 ? q[0].pc : last.pc);
    chk("train_taken", 32'(train_taken), 32'(q.size() > 0 ? q[0].taken : last.taken));
    chk("flush",       32'(flush),       32'(busy == FH + 1));
    chk("flush_pc",    flush_pc,         m_fpc);
    chk("mispred_cnt", 32'(mispred_cnt), 32'(m_cnt));
  endtask

  // Check current outputs, advance the model over the coming edge, then step past it.
  task automatic step();
    logic        ready_e, acc, mis;
    logic [31:0] act;
    check_all();
    ready_e = (busy == 0) && (q.size() < DEPTH);
    act     = res_taken ? res_target : res_pc + 32'd4;
    mis     = ((act ^ res_pred_pc) & MASK) != 0;
    if (q.size() > 0) last = q[0];
    if (rdy) begin
      acc = res_valid && ready_e;
      if (q.size() > 0 && train_ack) void'(q.pop_front());
      if (acc) q.push_back('{res_pc & MASK, res_taken});
      if (acc && mis) begin
        busy  = FH + 1;
        m_fpc = act & MASK;
        if (m_cnt < 65535) m_cnt++;
      end else if (busy > 0) busy--;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] pred, input logic ack);
    res_valid = v; res_pc = pc; res_taken = tk; res_target = tgt; res_pred_pc = pred;
    train_ack = ack;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(res_ready),   32'h0);
    chk({tag, "_flush"}, 32'(flush),       32'h0);
    chk({tag, "_tv"},    32'(train_valid), 32'h0);
    chk({tag, "_cnt"},   32'(mispred_cnt), 32'h0);
    chk({tag, "_fpc"},   flush_pc,         32'h0);
    chk({tag, "_tpc"},   train_pc,         32'h0);
  endtask

  initial begin
    logic [31:0] pc, tgt, act, pred;
    logic        tk;
    reset_model();
    #3 rst = 1'b0;
    #10 check_reset_state("por");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Correct prediction, then training handshake
    drive(1, 32'h100, 1, 32'h140, 32'h140, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_flush", 32'(flush), 32'h0);
    chk("t2_pc", train_pc, 32'h100);
    step();
    train_ack = 1; step();
    train_ack = 0; step();

    // Mispredict: not-taken fallthrough 0x204 vs predicted 0x180
    drive(1, 32'h200, 0, 32'h0, 32'h180, 0); step();
    drive(0, 0, 0, 0, 0, 1);
    chk("t3_flush", 32'(flush), 32'h1);
    chk("t3_fpc", flush_pc, 32'h204);
    chk("t3_cnt", 32'(mispred_cnt), 32'h1);
    repeat (4) step();

    // Fill the FIFO, then free one slot
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h300 + 32'(i * 4), 0, 0, 32'h304 + 32'(i * 4), 0); step();
    end
    chk("t4_full_ready", 32'(res_ready), 32'h0);
    train_ack = 1; step();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_ready_again", 32'(res_ready), 32'h1);
    train_ack = 1; repeat (4) step();

    // PC wrap: 0x1FFFC+4 masks to 0
    drive(1, 32'h1FFFC, 0, 0, 32'h0, 0); step();
    chk("t5_no_flush", 32'(flush), 32'h0);
    for (int i = 0; i < 10; i++) begin
      pc = 32'h1000 + 32'(i * 8);
      drive(1, pc, 0, 0, pc + 32'd4, 1); step();
    end
    drive(0, 0, 0, 0, 0, 1); repeat (2) step();

    // Freeze during FLUSH with valid and ack asserted
    drive(1, 32'h400, 1, 32'h480, 32'h404, 0); step();
    drive(1, 32'h500, 0, 0, 32'h0, 1); rdy = 0;
    repeat (3) step();
    chk("t6_flush_held", 32'(flush), 32'h1);
    chk("t6_fpc", flush_pc, 32'h480);
    rdy = 1; drive(0, 0, 0, 0, 0, 1); repeat (4) step();

    // Reset in the middle of a flush
    drive(1, 32'h600, 0, 0, 32'h0, 0); step();
    chk("t1_flush_pre", 32'(flush), 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0; #1;
    check_reset_state("t1");
    reset_model();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("t1_ready_post", 32'(res_ready), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      pc   = $urandom;
      tk   = 1'($urandom_range(0, 1));
      tgt  = $urandom;
      act  = tk ? tgt : pc + 32'd4;
      pred = ($urandom_range(0, 4) == 0) ? $urandom
           : act ^ (($urandom_range(0, 3) == 0) ? 32'hFFFE_0000 : 32'h0);
      drive(1'($urandom_range(0, 9) < 7), pc, tk, tgt, pred, 1'($urandom_range(0, 1)));
      rdy = ($urandom_range(0, 7) != 0);
      step();
    end
    rdy = 1; drive(0, 0, 0, 0, 0, 1); repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
